// File: rtl/bsc_hwcounter_pkg.sv
// Shared types and constants for the hardware cycle-counter snapshot arbiter.
// The counter slave exposes a 64-bit value as two 32-bit AXI-Lite read-only words.
package bsc_hwcounter_pkg;

    typedef enum logic [2:0] {
        FLUSH,
        IDLE,
        AR_LO,
        R_LO,
        AR_HI,
        R_HI,
        RESP
    } hwc_state_e;

    localparam logic [31:0] HWC_LO_OFS = 32'h0;
    localparam logic [31:0] HWC_HI_OFS = 32'h4;
    localparam logic [1:0]  RESP_OKAY  = 2'b00;

endpackage

// File: rtl/bsc_rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last retired grant.
// The grant is combinational; the caller freezes it and retires it through advance/adv_idx.
module bsc_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N <= 1) ? 1 : $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    input  logic [IW-1:0] adv_idx,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= (adv_idx == IW'(N - 1)) ? '0 : adv_idx + 1'b1;
        end
    end

    int   idx;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/bsc_hwcounter_snapshot_arbiter.sv
// Sole AXI-Lite read master of a 64-bit cycle-counter slave, shared among requesters.
// Each snapshot is a low read followed immediately by a high read; the slave latches high on low.
module bsc_hwcounter_snapshot_arbiter
    import bsc_hwcounter_pkg::*;
#(
    parameter int C_NUM_REQ          = 4,
    parameter int C_M_AXI_ADDR_WIDTH = 3,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = '0,
    parameter int C_FLUSH_CYCLES     = 4
) (
    input  logic                          m_axi_aclk,
    input  logic                          m_axi_areset,
    input  logic [C_NUM_REQ-1:0]          req_valid,
    output logic [C_NUM_REQ-1:0]          ack,
    output logic [63:0]                   ack_data,
    output logic                          ack_err,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready
);

    localparam int IW = (C_NUM_REQ <= 1) ? 1 : $clog2(C_NUM_REQ);
    localparam int FW = $clog2(C_FLUSH_CYCLES + 1);
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] LO_ADDR = C_BASE_ADDR + C_M_AXI_ADDR_WIDTH'(HWC_LO_OFS);
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] HI_ADDR = C_BASE_ADDR + C_M_AXI_ADDR_WIDTH'(HWC_HI_OFS);

    if (C_M_AXI_DATA_WIDTH != 32) begin : g_bad_width
        $error("bsc_hwcounter_snapshot_arbiter supports only 32-bit data");
    end

    hwc_state_e           state_q, state_d;
    logic [FW-1:0]        flush_cnt_q;
    logic [C_NUM_REQ-1:0] grant_q;
    logic [IW-1:0]        gidx_q;
    logic [63:0]          data_q;
    logic                 err_q;
    logic [C_NUM_REQ-1:0] arb_grant;
    logic [IW-1:0]        arb_idx;

    bsc_rr_arbiter #(
        .N  (C_NUM_REQ),
        .IW (IW)
    ) u_arb (
        .clk       (m_axi_aclk),
        .rst       (m_axi_areset),
        .req       (req_valid),
        .advance   (state_q == RESP),
        .adv_idx   (gidx_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FLUSH:   if (flush_cnt_q == '0) state_d = IDLE;
            IDLE:    if (|req_valid)        state_d = AR_LO;
            AR_LO:   if (m_axi_arready)     state_d = R_LO;
            R_LO:    if (m_axi_rvalid)      state_d = AR_HI;
            AR_HI:   if (m_axi_arready)     state_d = R_HI;
            R_HI:    if (m_axi_rvalid)      state_d = RESP;
            RESP:                           state_d = IDLE;
            default:                        state_d = FLUSH;
        endcase
    end

    // rready stays high through FLUSH so a beat orphaned by reset is swallowed.
    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            state_q     <= FLUSH;
            flush_cnt_q <= FW'(C_FLUSH_CYCLES - 1);
            grant_q     <= '0;
            gidx_q      <= '0;
            data_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == FLUSH && flush_cnt_q != '0) flush_cnt_q <= flush_cnt_q - 1'b1;
            unique case (state_q)
                IDLE: begin
                    err_q <= 1'b0;
                    if (|req_valid) begin
                        grant_q <= arb_grant;
                        gidx_q  <= arb_idx;
                    end
                end
                R_LO: if (m_axi_rvalid) begin
                    data_q[31:0] <= m_axi_rdata;
                    err_q        <= err_q | (m_axi_rresp != RESP_OKAY);
                end
                R_HI: if (m_axi_rvalid) begin
                    data_q[63:32] <= m_axi_rdata;
                    err_q         <= err_q | (m_axi_rresp != RESP_OKAY);
                end
                default: ;
            endcase
        end
    end

    assign ack           = (state_q == RESP) ? grant_q : '0;
    assign ack_data      = data_q;
    assign ack_err       = (state_q == RESP) && err_q;
    assign m_axi_arvalid = (state_q == AR_LO) || (state_q == AR_HI);
    assign m_axi_araddr  = (state_q == AR_HI) ? HI_ADDR : LO_ADDR;
    assign m_axi_rready  = (state_q == FLUSH) || (state_q == R_LO) || (state_q == R_HI);

endmodule
